lector_acumulado: RTL and testbench

LECTOR_ACUMULADO -- requirements
Module: lector_acumulado

---
 rtl/lector_acumulado.sv | 101 ++++++++++
 tb/tb_lector_acumulado.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lector_acumulado.sv
// Sample FIFO fed by an accumulator strobe; head word is held in a register (dato).
// Optional: define LECTOR_CNT_PERDIDOS_EN to add the saturating dropped-sample counter perdidos.
module lector_acumulado #(
  parameter int unsigned N     = 25,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [2*N-1:0]             Acumulado,
  input  logic                       signal,
  input  logic                       listo,
  output logic [2*N-1:0]             dato,
  output logic                       valido,
  output logic [$clog2(DEPTH):0]     nivel,
`ifdef LECTOR_CNT_PERDIDOS_EN
  output logic [7:0]                 perdidos,
`endif
  output logic                       desborde
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [2*N-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  rd_next;
  logic [LW-1:0]  nivel_q, nivel_d;
  logic [2*N-1:0] dato_q, dato_d;
  logic           desborde_q, desborde_d;
  logic           full, pop, do_push, drop;

  assign full    = (nivel_q == LW'(DEPTH));
  assign pop     = valido && listo;
  assign do_push = signal && (!full || pop);
  assign drop    = signal && full && !pop;
  assign rd_next = rd_ptr_q + 1'b1;

  assign valido   = (nivel_q != '0);
  assign nivel    = nivel_q;
  assign dato     = dato_q;
  assign desborde = desborde_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    nivel_d    = nivel_q;
    dato_d     = dato_q;
    desborde_d = desborde_q | drop;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_next;
    unique case ({do_push, pop})
      2'b10:   nivel_d = nivel_q + 1'b1;
      2'b01:   nivel_d = nivel_q - 1'b1;
      default: nivel_d = nivel_q;
    endcase
    // The head register tracks the word at rd_ptr; a new sample becomes head only
    // when nothing older remains behind the popped word.
    if (pop) begin
      if (nivel_q > LW'(1))  dato_d = mem[rd_next];
      else if (do_push)      dato_d = Acumulado;
    end else if (do_push && nivel_q == '0) begin
      dato_d = Acumulado;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      nivel_q    <= '0;
      dato_q     <= '0;
      desborde_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      nivel_q    <= nivel_d;
      dato_q     <= dato_d;
      desborde_q <= desborde_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && do_push) mem[wr_ptr_q] <= Acumulado;
  end

`ifdef LECTOR_CNT_PERDIDOS_EN
  logic [7:0] perdidos_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perdidos_q <= '0;
    end else if (drop && perdidos_q != 8'hff) begin
      perdidos_q <= perdidos_q + 8'd1;
    end
  end

  assign perdidos = perdidos_q;
`endif

endmodule

// File: tb/tb_lector_acumulado.sv
// Scoreboard bench for lector_acumulado: stimulus queues expected words, a negedge
// monitor compares dato whenever a pop is about to happen.
module tb_lector_acumulado;

  localparam int unsigned N     = 25;
  localparam int unsigned DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [2*N-1:0]         Acumulado;
  logic                   signal;
  logic                   listo;
  logic [2*N-1:0]         dato;
  logic                   valido;
  logic [$clog2(DEPTH):0] nivel;
  logic                   desborde;
`ifdef LECTOR_CNT_PERDIDOS_EN
  logic [7:0]             perdidos;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [2*N-1:0] sb_q [$];

  lector_acumulado #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Acumulado (Acumulado),
    .signal    (signal),
    .listo     (listo),
    .dato      (dato),
    .valido    (valido),
    .nivel     (nivel),
`ifdef LECTOR_CNT_PERDIDOS_EN
    .perdidos  (perdidos),
`endif
    .desborde  (desborde)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [2*N-1:0] val, input bit kept);
    Acumulado = val;
    signal    = 1'b1;
    if (kept) sb_q.push_back(val);
    tick();
    signal    = 1'b0;
  endtask

  task automatic do_reset();
    listo   = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sb_q.delete();
  endtask

  // Inputs settle 1ns after posedge, so at negedge they show what the next edge will see.
  always @(negedge clk) begin
    if (reset_n && valido && listo) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got 0x%0h, expected no word", dato);
      end else begin
        if (dato !== sb_q[0]) begin
          fails++;
          $display("FAIL sb_data: got 0x%0h, expected 0x%0h", dato, sb_q[0]);
        end
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    signal    = 1'b0;
    listo     = 1'b0;
    Acumulado = '0;
    tick();
    tick();
    reset_n = 1'b1;
    check("rst_nivel", 64'(nivel), 0);
    check("rst_valido", 64'(valido), 0);
    check("rst_desborde", 64'(desborde), 0);
    check("rst_dato", 64'(dato), 0);

    // Single push then pop
    strobe(50'h123, 1'b1);
    check("single_valido", 64'(valido), 1);
    check("single_nivel", 64'(nivel), 1);
    check("single_dato", 64'(dato), 64'h123);
    listo = 1'b1;
    tick();
    listo = 1'b0;
    check("single_pop_valido", 64'(valido), 0);
    check("single_pop_nivel", 64'(nivel), 0);

    // Empty with listo: no underflow
    listo = 1'b1;
    tick();
    tick();
    listo = 1'b0;
    check("empty_listo_nivel", 64'(nivel), 0);

    // Overflow: 5 strobes into depth 4
    for (int i = 1; i <= 5; i++) begin
      strobe(50'(i), i <= 4);
      check($sformatf("ovf_desborde_%0d", i), 64'(desborde), (i == 5) ? 1 : 0);
    end
    check("ovf_nivel", 64'(nivel), 4);
`ifdef LECTOR_CNT_PERDIDOS_EN
    check("ovf_perdidos", 64'(perdidos), 1);
`endif
    listo = 1'b1;
    repeat (4) tick();
    listo = 1'b0;
    check("ovf_drain_nivel", 64'(nivel), 0);
    check("ovf_sticky", 64'(desborde), 1);

    // Full with simultaneous pop
    do_reset();
    check("rst2_desborde", 64'(desborde), 0);
    for (int i = 0; i < 4; i++) strobe(50'(8'h11 + i), 1'b1);
    check("fullpop_pre_nivel", 64'(nivel), 4);
    listo = 1'b1;
    strobe(50'h9, 1'b1);
    listo = 1'b0;
    check("fullpop_nivel", 64'(nivel), 4);
    check("fullpop_desborde", 64'(desborde), 0);
    check("fullpop_head", 64'(dato), 64'h12);
    listo = 1'b1;
    repeat (4) tick();
    listo = 1'b0;
    check("fullpop_drain_nivel", 64'(nivel), 0);

    // Streaming with listo high: pointers wrap 5 times
    listo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      strobe(50'(i), 1'b1);
      check($sformatf("stream_nivel_%0d", i), 64'(nivel), 1);
    end
    tick();
    listo = 1'b0;
    check("stream_nivel_end", 64'(nivel), 0);
    check("stream_desborde", 64'(desborde), 0);

    // Reset mid-stream at nivel=3
    for (int i = 0; i < 3; i++) strobe(50'(8'h31 + i), 1'b1);
    check("mid_pre_nivel", 64'(nivel), 3);
    do_reset();
    check("mid_nivel", 64'(nivel), 0);
    check("mid_valido", 64'(valido), 0);
    check("mid_desborde", 64'(desborde), 0);
    check("mid_dato", 64'(dato), 0);
    strobe(50'hAA, 1'b1);
    check("mid_after_dato", 64'(dato), 64'hAA);
    check("mid_after_valido", 64'(valido), 1);
    listo = 1'b1;
    tick();
    listo = 1'b0;

    // Strobe during reset is lost
    reset_n   = 1'b0;
    Acumulado = 50'h55;
    signal    = 1'b1;
    tick();
    signal  = 1'b0;
    reset_n = 1'b1;
    check("rst_dom_nivel", 64'(nivel), 0);
    check("rst_dom_valido", 64'(valido), 0);

`ifdef LECTOR_CNT_PERDIDOS_EN
    // Counter saturation
    for (int i = 0; i < 4; i++) strobe(50'(i + 100), 1'b1);
    for (int i = 0; i < 300; i++) strobe(50'(i), 1'b0);
    check("sat_perdidos", 64'(perdidos), 255);
    check("sat_nivel", 64'(nivel), 4);
    listo = 1'b1;
    repeat (4) tick();
    listo = 1'b0;
`endif

    check("sb_empty", 64'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
